// File: rtl/adiabatic_pclk_gen.sv
// Four-phase trapezoidal power-clock sequencer for adiabatic logic rails.
// Emits per-phase stepwise ramp codes, complementary codes and flat-top flags.
module adiabatic_pclk_gen #(
    parameter int unsigned LVLW     = 4,
    parameter int unsigned STEP_DIV = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                busy,
    output logic                qsync,
    output logic [4*LVLW-1:0]   pos_lvl,
    output logic [4*LVLW-1:0]   neg_lvl,
    output logic [3:0]          clkpos,
    output logic [3:0]          clkneg,
    output logic [3:0]          active
);

    localparam int unsigned     SUBW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SUBW-1:0] SUB_LAST  = SUBW'(STEP_DIV - 1);
    localparam logic [LVLW-1:0] MAX       = '1;
    localparam logic [LVLW-1:0] STEP_LAST = MAX - 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t             r_state, w_state_n;
    logic [SUBW-1:0]    r_sub, w_sub_n;
    logic [LVLW-1:0]    r_step, w_step_n;
    logic [1:0]         r_q, w_q_n;
    logic [3:0]         r_act, w_act_n;
    logic               w_wrap;

    logic               r_busy, r_qsync;
    logic [4*LVLW-1:0]  r_pos, r_neg, w_pos_n, w_neg_n;
    logic [3:0]         r_clkpos, r_clkneg, w_clkpos_n, w_clkneg_n;
    logic [LVLW-1:0]    w_lvl [4];
    logic               w_qsync_n;

    // cnt within a quarter is kept as (step, sub) so cnt/STEP_DIV is simply step
    assign w_wrap = (r_sub == SUB_LAST) && (r_step == STEP_LAST);

    always_comb begin
        w_state_n = r_state;
        w_sub_n   = r_sub;
        w_step_n  = r_step;
        w_q_n     = r_q;
        w_act_n   = r_act;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_n = ST_RUN;
                    w_sub_n   = '0;
                    w_step_n  = '0;
                    w_q_n     = '0;
                    w_act_n   = 4'b0001;
                end
            end
            default: begin
                w_state_n = en ? ST_RUN : ST_DRAIN;
                if (w_wrap) begin
                    w_sub_n  = '0;
                    w_step_n = '0;
                    w_q_n    = r_q + 2'd1;
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (w_q_n == 2'(k))
                            w_act_n[k] = en;
                        else if (w_q_n == 2'(k + 3))
                            w_act_n[k] = 1'b0;
                    end
                    if (!en && (w_act_n == '0)) begin
                        w_state_n = ST_IDLE;
                        w_q_n     = '0;
                    end
                end else if (r_sub == SUB_LAST) begin
                    w_sub_n  = '0;
                    w_step_n = r_step + 1'b1;
                end else begin
                    w_sub_n = r_sub + 1'b1;
                end
            end
        endcase
    end

    // Outputs are registered from the next-state values so they align with the counters
    always_comb begin
        w_pos_n    = '0;
        w_neg_n    = '0;
        w_clkpos_n = '0;
        w_clkneg_n = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            w_lvl[k] = '0;
            if (w_act_n[k]) begin
                if (w_q_n == 2'(k))
                    w_lvl[k] = w_step_n + 1'b1;
                else if (w_q_n == 2'(k + 1))
                    w_lvl[k] = MAX;
                else if (w_q_n == 2'(k + 2))
                    w_lvl[k] = STEP_LAST - w_step_n;
            end
            w_pos_n[k*LVLW +: LVLW] = w_lvl[k];
            w_neg_n[k*LVLW +: LVLW] = MAX - w_lvl[k];
            w_clkpos_n[k]           = (w_lvl[k] == MAX);
            w_clkneg_n[k]           = (w_lvl[k] == '0);
        end
        w_qsync_n = (w_state_n != ST_IDLE) && (w_q_n == '0) &&
                    (w_step_n == '0) && (w_sub_n == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sub    <= '0;
            r_step   <= '0;
            r_q      <= '0;
            r_act    <= '0;
            r_busy   <= 1'b0;
            r_qsync  <= 1'b0;
            r_pos    <= '0;
            r_neg    <= '1;
            r_clkpos <= '0;
            r_clkneg <= '1;
        end else begin
            r_state  <= w_state_n;
            r_sub    <= w_sub_n;
            r_step   <= w_step_n;
            r_q      <= w_q_n;
            r_act    <= w_act_n;
            r_busy   <= (w_state_n != ST_IDLE);
            r_qsync  <= w_qsync_n;
            r_pos    <= w_pos_n;
            r_neg    <= w_neg_n;
            r_clkpos <= w_clkpos_n;
            r_clkneg <= w_clkneg_n;
        end
    end

    assign busy    = r_busy;
    assign qsync   = r_qsync;
    assign pos_lvl = r_pos;
    assign neg_lvl = r_neg;
    assign clkpos  = r_clkpos;
    assign clkneg  = r_clkneg;
    assign active  = r_act;

endmodule

// File: tb/tb_adiabatic_pclk_gen.sv
// Self-checking bench: two instances (LVLW=4/STEP_DIV=2 and LVLW=2/STEP_DIV=1)
// compared each cycle against a time-based trapezoid model.
module tb_adiabatic_pclk_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;

    logic        busy0, qsync0, busy1, qsync1;
    logic [15:0] pos0, neg0;
    logic [7:0]  pos1, neg1;
    logic [3:0]  cp0, cn0, act0, cp1, cn1, act1;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int       m_t   [2];
    bit       m_on  [2];
    bit [3:0] m_act [2];
    int       prev  [2][4];
    int       lastq [2];

    adiabatic_pclk_gen #(.LVLW(4), .STEP_DIV(2)) dut0 (
        .clk(clk), .rst(rst), .en(en), .busy(busy0), .qsync(qsync0),
        .pos_lvl(pos0), .neg_lvl(neg0), .clkpos(cp0), .clkneg(cn0), .active(act0)
    );

    adiabatic_pclk_gen #(.LVLW(2), .STEP_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .busy(busy1), .qsync(qsync1),
        .pos_lvl(pos1), .neg_lvl(neg1), .clkpos(cp1), .clkneg(cn1), .active(act1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_on[i]  = 0;
            m_t[i]   = 0;
            m_act[i] = '0;
            lastq[i] = -1;
            for (int k = 0; k < 4; k++) prev[i][k] = 0;
        end
    endtask

    // One clock of the model: time t counts cycles since start; quarters are t/Q
    task automatic model_step(input int i, input bit e, input int q_len);
        int qq;
        if (!m_on[i]) begin
            if (e) begin
                m_on[i]  = 1;
                m_t[i]   = 0;
                m_act[i] = 4'b0001;
            end
        end else begin
            m_t[i]++;
            if (m_t[i] % q_len == 0) begin
                qq = (m_t[i] / q_len) % 4;
                for (int k = 0; k < 4; k++) begin
                    if ((qq - k + 4) % 4 == 0) m_act[i][k] = e;
                    if ((qq - k + 4) % 4 == 3) m_act[i][k] = 0;
                end
                if (!e && m_act[i] == 0) m_on[i] = 0;
            end
        end
    endtask

    function automatic int mlvl(input int i, input int k, input int lw, input int sd);
        int mx, q_len, c, role;
        mx    = (1 << lw) - 1;
        q_len = mx * sd;
        if (!m_on[i] || !m_act[i][k]) return 0;
        c    = m_t[i] % q_len;
        role = ((m_t[i] / q_len) % 4 - k + 4) % 4;
        case (role)
            0:       return c / sd + 1;
            1:       return mx;
            2:       return mx - 1 - c / sd;
            default: return 0;
        endcase
    endfunction

    task automatic check_inst(input int i, input int lw, input int sd,
                              input logic [31:0] pos, input logic [31:0] neg,
                              input logic [3:0] cp, input logic [3:0] cn,
                              input logic [3:0] act, input logic bsy, input logic qs);
        logic [31:0] epos, eneg;
        logic [3:0]  ecp, ecn;
        int mx, l, o, d;
        bit slew_ok;
        mx = (1 << lw) - 1;
        epos = 0; eneg = 0; ecp = 0; ecn = 0; slew_ok = 1;
        for (int k = 0; k < 4; k++) begin
            l = mlvl(i, k, lw, sd);
            epos |= 32'(l) << (k * lw);
            eneg |= 32'(mx - l) << (k * lw);
            ecp[k] = (l == mx);
            ecn[k] = (l == 0);
            o = int'((pos >> (k * lw)) & 32'(mx));
            d = o - prev[i][k];
            if (d > 1 || d < -1) slew_ok = 0;
            prev[i][k] = o;
        end
        check($sformatf("d%0d_pos", i), pos, epos);
        check($sformatf("d%0d_neg", i), neg, eneg);
        check($sformatf("d%0d_clkpos", i), 32'(cp), 32'(ecp));
        check($sformatf("d%0d_clkneg", i), 32'(cn), 32'(ecn));
        check($sformatf("d%0d_active", i), 32'(act), 32'(m_on[i] ? m_act[i] : 4'b0));
        check($sformatf("d%0d_busy", i), 32'(bsy), 32'(m_on[i]));
        check($sformatf("d%0d_qsync", i), 32'(qs),
              32'(m_on[i] && (m_t[i] % (4 * mx * sd) == 0)));
        check($sformatf("d%0d_slew", i), 32'(slew_ok), 32'd1);
        if (!bsy) lastq[i] = -1;
        if (qs) begin
            if (lastq[i] >= 0)
                check($sformatf("d%0d_qsync_period", i), 32'(cyc - lastq[i]), 32'(4 * mx * sd));
            lastq[i] = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, en, 30);
        model_step(1, en, 3);
        cyc++;
        #1;
        check_inst(0, 4, 2, 32'(pos0), 32'(neg0), cp0, cn0, act0, busy0, qsync0);
        check_inst(1, 2, 1, 32'(pos1), 32'(neg1), cp1, cn1, act1, busy1, qsync1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pos0"}, 32'(pos0), 32'h0);
        check({tag, "_neg0"}, 32'(neg0), 32'hFFFF);
        check({tag, "_clkneg0"}, 32'(cn0), 32'hF);
        check({tag, "_clkpos0"}, 32'(cp0), 32'h0);
        check({tag, "_busy0"}, 32'(busy0), 32'h0);
        check({tag, "_qsync0"}, 32'(qsync0), 32'h0);
        check({tag, "_active0"}, 32'(act0), 32'h0);
        check({tag, "_pos1"}, 32'(pos1), 32'h0);
        check({tag, "_neg1"}, 32'(neg1), 32'hFF);
        check({tag, "_busy1"}, 32'(busy1), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (3) tick();

        // Startup
        en = 1'b1;
        tick();
        check("start_pos0_ph0", 32'(pos0[3:0]), 32'd1);
        check("start_qsync", 32'(qsync0), 32'd1);
        repeat (29) tick();
        check("n29_pos0_ph0", 32'(pos0[3:0]), 32'd15);
        check("n29_clkpos0", 32'(cp0[0]), 32'd1);
        tick();
        check("n30_pos0_ph1", 32'(pos0[7:4]), 32'd1);
        check("n30_pos0_ph23", 32'(pos0[15:8]), 32'd0);

        // Steady state, 8 periods
        repeat (960) tick();

        // Drain from phase 0 HOLD
        for (int i = 0; i < 130 && (m_t[0] % 120 != 40); i++) tick();
        en = 1'b0;
        for (int i = 0; i < 300 && (m_on[0] || busy0); i++) tick();
        check("drain_busy0", 32'(busy0), 32'd0);
        check("drain_pos0", 32'(pos0), 32'd0);
        repeat (5) tick();

        // Re-enable within one quarter of dropping en
        en = 1'b1;
        repeat (150) tick();
        for (int i = 0; i < 40 && (m_t[0] % 30 != 5); i++) tick();
        en = 1'b0;
        repeat (5) tick();
        en = 1'b1;
        repeat (300) tick();

        // Random run/stop segments
        for (int s = 0; s < 20; s++) begin
            en = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 200)) tick();
        end

        // Asynchronous reset mid-run
        en = 1'b1;
        repeat (45) tick();
        rst = 1'b1;
        #1;
        check_reset_vals("midrun_rst");
        model_reset();
        #2;
        rst = 1'b0;
        en  = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
